inst_mem_responder: RTL
=======================

Name: inst_mem_responder

Overview:
- Responder end of the fetch-side instruction memory interface: accepts word-read requests from the fetch unit and returns instruction and PC with a valid flag, honouring the downstream stall.
- Also provides a program-load write port so the boot loader/testbench can fill instruction memory.
- Sits between the fetch unit and the instruction array.
- Replaces direct macro hookup with a handshaked, ordered, 2-deep response path with flush support.

Parameters:
CORE, 0, core id printed in report output
DATA_WIDTH, 32, instruction/word width
ADDRESS_BITS, 20, byte-address width of request/response PC
INDEX_BITS, 12, word-index bits; array depth = 2^INDEX_BITS words
RESP_DEPTH, 2, max outstanding reads (in-flight + buffered); fixed at 2 for this revision

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
read  input  1  fetch read request
address  input  ADDRESS_BITS  request byte address
write  input  1  program-load write strobe
in_data  input  DATA_WIDTH  program-load write data (address supplied on address)
flush  input  1  discard all outstanding/buffered responses (redirect)
stall  input  1  consumer cannot accept response this cycle
ready  output  1  read request will be accepted this cycle
valid  output  1  out_data/out_addr hold a response
out_data  output  DATA_WIDTH  instruction word
out_addr  output  ADDRESS_BITS  byte address of the returned word (low 2 bits zero)
misaligned  output  1  one-cycle pulse: an accepted read had address[1:0] != 0
report  input  1  print state via $display this cycle

Behaviour:
- Word index = address[INDEX_BITS+1:2]; bits above the index and bits [1:0] are ignored for array access. out_addr = {index,2'b00}, zero-extended to ADDRESS_BITS.
- Write: when write=1, mem[index] <= in_data at the edge. Write has priority; ready=0 in any cycle with write=1, so a simultaneous read is not accepted.
- Accept: read && ready at edge c. Response becomes visible (valid=1) in cycle c+1 at the earliest, then stays valid until popped.
- Read-during-write is not possible by construction. A read accepted after a write edge returns the new data.
- Pop: valid && !stall at an edge retires the head response.
- Responses are returned strictly in request order.
- occ = in-flight (0/1) + buffered (0..2).
- ready = !write && (occ - pop) < RESP_DEPTH, where pop is this cycle's pop. ready is combinational on stall; it must not depend on read.
- No-stall throughput: one read per cycle, back-to-back. out_data changes every cycle.
- Stall: head out_data/out_addr/valid are held stable. At most one further accepted read is captured (skid). Then ready=0 until a pop.
- Flush at edge: all in-flight and buffered responses are dropped; valid=0 next cycle.
  - A read accepted in the same cycle as flush is kept. It is the only outstanding entry afterward, valid in cycle c+1.
  - flush and pop in the same cycle: flush wins; nothing is counted twice.
- misaligned: registered. Pulses in cycle c+1 for a read accepted at c with address[1:0]!=0. The read still completes using the truncated index.
- Reset (any cycle, including mid-stream): occ=0, all buffers invalid.
  - valid=0, misaligned=0, ready=1 (when write=0), out_data=0, out_addr=0.
  - Memory contents are NOT cleared.
  - Requests presented during reset are ignored.
- Cycle counter: cycles <= reset ? 0 : cycles+1.
- report=1: $display of CORE, cycles, read/write/address, occ, ready, valid, out_addr, out_data, stall, flush.
- Outputs out_data/out_addr are don't-care when valid=0 but must be 0 after reset until the first response.

Test Plan:
1. Reset, then idle → valid=0, ready=1, out_addr=0, out_data=0, misaligned=0.
2. Preload mem[0..3] = 0x00000013, 0x00100093, 0x00200113, 0x00300193 via write; read 0x0,0x4,0x8,0xC back-to-back, stall=0 → valid in 4 consecutive cycles starting one cycle after first accept; data in order; out_addr 0x0..0xC.
3. Same stream with stall=1 from first response for 3 cycles → head (0x0, 0x00000013) held; ready drops after 2 outstanding; after stall release, remaining responses delivered in order with none lost or duplicated.
4. Two reads outstanding, flush=1 together with read of 0x8 → only 0x8/0x00200113 returned, next cycle; earlier responses never appear.
5. write=1 and read=1 same cycle at 0x10 with in_data=0xDEADBEEF → ready=0, read not accepted. Read of 0x10 next cycle → 0xDEADBEEF.
6. Read 0x6 → out_addr=0x4, data of mem[1], misaligned pulse for one cycle. Assert reset with 2 outstanding → valid=0 next cycle, memory still holds preloaded values.

Source files
------------

// File: rtl/inst_mem_responder.sv
// Fetch-side instruction memory responder: ordered, 2-deep response
// buffer with stall skid, flush, and a program-load write port.
module inst_mem_responder #(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int INDEX_BITS   = 12,
    parameter int RESP_DEPTH   = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    read,
    input  logic [ADDRESS_BITS-1:0] address,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    flush,
    input  logic                    stall,
    output logic                    ready,
    output logic                    valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [ADDRESS_BITS-1:0] out_addr,
    output logic                    misaligned,
    input  logic                    report
);

    typedef struct packed {
        logic [ADDRESS_BITS-1:0] addr;
        logic [DATA_WIDTH-1:0]   data;
    } resp_t;

    localparam logic [1:0] DEPTH = 2'(RESP_DEPTH);

    logic [DATA_WIDTH-1:0] mem [2**INDEX_BITS];

    logic [INDEX_BITS-1:0] index;
    resp_t                 req;
    resp_t                 head;
    resp_t                 tail;
    logic [1:0]            occ;
    logic                  pop;
    logic                  accept;
    logic [31:0]           cycles;
    logic                  unused_addr;

    assign index       = address[INDEX_BITS+1:2];
    assign unused_addr = ^address[ADDRESS_BITS-1:INDEX_BITS+2];
    assign req.addr    = ADDRESS_BITS'({index, 2'b00});
    assign req.data    = mem[index];

    assign valid    = occ != 2'd0;
    assign pop      = valid && !stall;
    assign ready    = !write && ((occ - {1'b0, pop}) < DEPTH);
    assign accept   = read && ready;
    assign out_data = head.data;
    assign out_addr = head.addr;

    // Array is never reset so a loaded program survives a core reset.
    always_ff @(posedge clock) begin
        if (write) begin
            mem[index] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            occ        <= 2'd0;
            head       <= '0;
            tail       <= '0;
            misaligned <= 1'b0;
        end else begin
            misaligned <= accept && (address[1:0] != 2'b00);
            if (flush) begin
                // A read accepted alongside the redirect is the new stream head.
                if (accept) begin
                    head <= req;
                    occ  <= 2'd1;
                end else begin
                    occ  <= 2'd0;
                end
            end else if (pop && accept) begin
                if (occ == 2'd1) begin
                    head <= req;
                end else begin
                    head <= tail;
                    tail <= req;
                end
            end else if (pop) begin
                head <= tail;
                occ  <= occ - 2'd1;
            end else if (accept) begin
                if (occ == 2'd0) begin
                    head <= req;
                end else begin
                    tail <= req;
                end
                occ <= occ + 2'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycles <= 32'd0;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (report) begin
            $display("core %0d cyc %0d rd=%b wr=%b a=%h occ=%0d rdy=%b v=%b oa=%h od=%h st=%b fl=%b",
                     CORE, cycles, read, write, address, occ, ready, valid,
                     out_addr, out_data, stall, flush);
        end
    end
`endif

endmodule
